data_mem_responder: RTL and testbench

// - Responder side of the pipeline's data-memory port: services load/store requests issued by the
//   CPU memory stage over a valid/ready request, one-cycle-pulse response handshake.
// - Holds the word-addressed data RAM and models a fixed access latency.
// - Drives a stall flag to the hazard logic so the pipeline freezes while an access is outstanding.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/sp_ram.sv | 31 +++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM state encoding and captured request.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_pkg;

    // CPU word width; the request struct is sized to it.
    localparam int MEM_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic                 write;
        logic [MEM_WIDTH-1:0] address;
        logic [MEM_WIDTH-1:0] writeData;
    } mem_req_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous word RAM with write enable and registered read port.
// Latency: read data appears one edge after an enabled read; writes commit on the edge.
// Backpressure: none; accepts an access on every enabled edge.
module sp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array and read register are deliberately unreset; a write leaves rdData untouched
    // so the last load result stays visible to the consumer.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wrData;
            end else begin
                rdData <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serialised load/store to a word RAM with a fixed access latency.
// Latency: response pulse LATENCY edges after acceptance (directly on the accept edge when LATENCY==1).
// Backpressure: reqReady low while an access is outstanding; stall tells the pipeline to hold.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH   = MEM_WIDTH,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic             reqWrite,
    input  logic [WIDTH-1:0] reqAddress,
    input  logic [WIDTH-1:0] reqWriteData,
    output logic             respValid,
    output logic [WIDTH-1:0] respData,
    output logic             respError,
    output logic             stall
);

    // Counter wide enough to hold LATENCY-1, never narrower than one bit.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t       state;
    mem_state_t       nextState;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             finish;
    mem_req_t         liveReq;
    mem_req_t         capReq;
    mem_req_t         accessReq;
    logic             outOfRange;
    logic             loadSel;
    logic [WIDTH-1:0] ramRdata;

    assign liveReq = '{write: reqWrite, address: reqAddress, writeData: reqWriteData};

    // With a single-cycle latency the access happens on the accept edge itself, so the
    // live request feeds the RAM; otherwise the captured copy does.
    assign accessReq = (LATENCY == 1) ? liveReq : capReq;

    // Any set bit above the RAM index is an error rather than an alias.
    assign outOfRange = (accessReq.address >> AW) != '0;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, handshake and stall decode.
    always_comb begin
        nextState = state;
        finish    = 1'b0;
        reqReady  = (state == IDLE) || (state == RESP);
        accept    = reqValid && reqReady;
        stall     = (state == WAIT) || (reqValid && !reqReady);
        unique case (state)
            IDLE, RESP: begin
                if (reqValid) begin
                    nextState = (LATENCY == 1) ? RESP : WAIT;
                    finish    = (LATENCY == 1);
                end else begin
                    nextState = IDLE;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    nextState = RESP;
                    finish    = 1'b1;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Latency counter: loaded on accept, counts down through WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(LATENCY - 1);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Capture the request on acceptance; the CPU may change its inputs afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            capReq <= '0;
        end else if (accept) begin
            capReq <= liveReq;
        end
    end

    // Response qualifiers; respError and the load select hold until the next completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            respValid <= 1'b0;
            respError <= 1'b0;
            loadSel   <= 1'b0;
        end else begin
            respValid <= finish;
            if (finish) begin
                respError <= outOfRange;
                loadSel   <= !outOfRange && !accessReq.write;
            end
        end
    end

    // Stores, errors and reset all present zero; loads present the RAM read register.
    assign respData = loadSel ? ramRdata : '0;

    sp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock  (clock),
        .en     (finish && !outOfRange),
        .we     (accessReq.write),
        .addr   (accessReq.address[AW-1:0]),
        .wrData (accessReq.writeData),
        .rdData (ramRdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
// Latency: stimulus driven and outputs sampled on the falling clock edge.
// Backpressure: the bench holds each request until the responder accepts it.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic        clock;
    logic        reset;

    logic        rValid, rReady, rWrite;
    logic [15:0] rAddr, rWData;
    logic        pValid, pErr, stall0;
    logic [15:0] pData;

    logic        rValid1, rReady1, rWrite1;
    logic [15:0] rAddr1, rWData1;
    logic        pValid1, pErr1, stall1;
    logic [15:0] pData1;

    int testsRun    = 0;
    int testsFailed = 0;

    data_mem_responder #(.WIDTH(16), .DEPTH(256), .LATENCY(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (rValid),
        .reqReady     (rReady),
        .reqWrite     (rWrite),
        .reqAddress   (rAddr),
        .reqWriteData (rWData),
        .respValid    (pValid),
        .respData     (pData),
        .respError    (pErr),
        .stall        (stall0)
    );

    data_mem_responder #(.WIDTH(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (rValid1),
        .reqReady     (rReady1),
        .reqWrite     (rWrite1),
        .reqAddress   (rAddr1),
        .reqWriteData (rWData1),
        .respValid    (pValid1),
        .respData     (pData1),
        .respError    (pErr1),
        .stall        (stall1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input bit onL1, input bit v, input bit w,
                         input logic [15:0] a, input logic [15:0] d);
        if (onL1) begin
            rValid1 = v; rWrite1 = w; rAddr1 = a; rWData1 = d;
        end else begin
            rValid  = v; rWrite  = w; rAddr  = a; rWData  = d;
        end
    endtask

    // One request on an idle responder. lat = falling edges after the accept edge's falling
    // edge until respValid is seen (20 means it never came).
    task automatic doReq(input bit onL1, input bit w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] data, output logic err,
                         output bit sawStall, output bit sawWait);
        lat = 0; sawStall = 0; sawWait = 0;
        @(negedge clock);
        drive(onL1, 1'b1, w, a, d);
        @(negedge clock);
        drive(onL1, 1'b0, 1'b0, 16'h0, 16'h0);
        forever begin
            if (onL1 ? stall1 : stall0) sawStall = 1;
            if (onL1 && dut1.state == WAIT) sawWait = 1;
            if ((onL1 ? pValid1 : pValid) || lat >= 20) break;
            @(negedge clock);
            lat++;
        end
        data = onL1 ? pData1 : pData;
        err  = onL1 ? pErr1  : pErr;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        testsRun++; if (rReady !== 1'b1) begin testsFailed++; $display("FAIL reset_reqReady got %b want 1", rReady); end
        testsRun++; if (pValid !== 1'b0) begin testsFailed++; $display("FAIL reset_respValid got %b want 0", pValid); end
        testsRun++; if (pData !== 16'h0) begin testsFailed++; $display("FAIL reset_respData got %h want 0000", pData); end
        testsRun++; if (pErr !== 1'b0) begin testsFailed++; $display("FAIL reset_respError got %b want 0", pErr); end
        testsRun++; if (stall0 !== 1'b0) begin testsFailed++; $display("FAIL reset_stall got %b want 0", stall0); end
        testsRun++; if (rReady1 !== 1'b1) begin testsFailed++; $display("FAIL reset_reqReady_l1 got %b want 1", rReady1); end
    endtask

    // Known contents for later loads; results are checked by the feature tests.
    task automatic preload();
        int lat; logic [15:0] data; logic err; bit s, wt;
        doReq(0, 1, 16'h0000, 16'h1111, lat, data, err, s, wt);
        doReq(0, 1, 16'h0001, 16'h0101, lat, data, err, s, wt);
        doReq(0, 1, 16'h0002, 16'h0202, lat, data, err, s, wt);
        doReq(0, 1, 16'h0003, 16'h0303, lat, data, err, s, wt);
        doReq(0, 1, 16'h0005, 16'h5555, lat, data, err, s, wt);
    endtask

    task automatic test_store_load();
        int lat; logic [15:0] data; logic err; bit s, wt;
        doReq(0, 1, 16'h0010, 16'h00A5, lat, data, err, s, wt);
        testsRun++; if (lat !== 2) begin testsFailed++; $display("FAIL store_latency got %0d want 2", lat); end
        testsRun++; if (data !== 16'h0) begin testsFailed++; $display("FAIL store_respData got %h want 0000", data); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("FAIL store_respError got %b want 0", err); end
        testsRun++; if (s !== 1'b1) begin testsFailed++; $display("FAIL store_stall_in_wait got %b want 1", s); end
        doReq(0, 0, 16'h0010, 16'h0, lat, data, err, s, wt);
        testsRun++; if (lat !== 2) begin testsFailed++; $display("FAIL load_latency got %0d want 2", lat); end
        testsRun++; if (data !== 16'h00A5) begin testsFailed++; $display("FAIL load_respData got %h want 00a5", data); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("FAIL load_respError got %b want 0", err); end
        @(negedge clock);
        testsRun++; if (pValid !== 1'b0) begin testsFailed++; $display("FAIL pulse_width respValid got %b want 0", pValid); end
        testsRun++; if (pData !== 16'h00A5) begin testsFailed++; $display("FAIL respData_hold got %h want 00a5", pData); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] data; logic err; bit s, wt;
        doReq(0, 1, 16'h0100, 16'h1234, lat, data, err, s, wt);
        testsRun++; if (err !== 1'b1) begin testsFailed++; $display("FAIL oor_store_respError got %b want 1", err); end
        testsRun++; if (data !== 16'h0) begin testsFailed++; $display("FAIL oor_store_respData got %h want 0000", data); end
        doReq(0, 0, 16'h0000, 16'h0, lat, data, err, s, wt);
        testsRun++; if (data !== 16'h1111) begin testsFailed++; $display("FAIL oor_mem0_unchanged got %h want 1111", data); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("FAIL oor_mem0_respError got %b want 0", err); end
        doReq(0, 0, 16'h8000, 16'h0, lat, data, err, s, wt);
        testsRun++; if (err !== 1'b1) begin testsFailed++; $display("FAIL oor_msb_load_respError got %b want 1", err); end
        testsRun++; if (data !== 16'h0) begin testsFailed++; $display("FAIL oor_msb_load_respData got %h want 0000", data); end
    endtask

    // Loads of 1,2,3 with reqValid held: pulses expected at falling edges 3, 6, 9;
    // stall high during the two WAIT cycles before each pulse.
    task automatic test_back_to_back();
        int idx = 0;
        int pulses = 0;
        bit accNext = 0;
        logic expV, expS;
        logic [15:0] expData;
        @(negedge clock);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clock);
            expV = (k == 3 || k == 6 || k == 9);
            expS = (k == 1 || k == 2 || k == 4 || k == 5 || k == 7 || k == 8);
            testsRun++; if (pValid !== expV) begin testsFailed++; $display("FAIL b2b_respValid[%0d] got %b want %b", k, pValid, expV); end
            testsRun++; if (stall0 !== expS) begin testsFailed++; $display("FAIL b2b_stall[%0d] got %b want %b", k, stall0, expS); end
            if (pValid === 1'b1) begin
                pulses++;
                expData = 16'(pulses * 257);
                testsRun++; if (pData !== expData) begin testsFailed++; $display("FAIL b2b_respData[%0d] got %h want %h", k, pData, expData); end
            end
            if (accNext) idx++;
            if (idx < 3) drive(0, 1'b1, 1'b0, 16'(idx + 1), 16'h0);
            else         drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            accNext = rValid && rReady;
        end
        testsRun++; if (pulses !== 3) begin testsFailed++; $display("FAIL b2b_pulse_count got %0d want 3", pulses); end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [15:0] data; logic err; bit s, wt;
        bit saw = 0;
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
        @(negedge clock);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        testsRun++; if (stall0 !== 1'b1) begin testsFailed++; $display("FAIL midwait_stall got %b want 1", stall0); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (pValid) saw = 1;
        end
        testsRun++; if (saw !== 1'b0) begin testsFailed++; $display("FAIL midwait_no_response got %b want 0", saw); end
        doReq(0, 0, 16'h0005, 16'h0, lat, data, err, s, wt);
        testsRun++; if (data !== 16'h5555) begin testsFailed++; $display("FAIL midwait_store_dropped got %h want 5555", data); end
    endtask

    task automatic test_latency1();
        int lat; logic [15:0] data; logic err; bit s, wt;
        doReq(1, 1, 16'h0009, 16'h7777, lat, data, err, s, wt);
        testsRun++; if (lat !== 0) begin testsFailed++; $display("FAIL l1_store_latency got %0d want 0", lat); end
        doReq(1, 0, 16'h0009, 16'h0, lat, data, err, s, wt);
        testsRun++; if (lat !== 0) begin testsFailed++; $display("FAIL l1_load_latency got %0d want 0", lat); end
        testsRun++; if (data !== 16'h7777) begin testsFailed++; $display("FAIL l1_load_respData got %h want 7777", data); end
        testsRun++; if (s !== 1'b0) begin testsFailed++; $display("FAIL l1_stall got %b want 0", s); end
        testsRun++; if (wt !== 1'b0) begin testsFailed++; $display("FAIL l1_entered_wait got %b want 0", wt); end
        @(negedge clock);
        testsRun++; if (pValid1 !== 1'b0) begin testsFailed++; $display("FAIL l1_pulse_width got %b want 0", pValid1); end
        testsRun++; if (stall1 !== 1'b0) begin testsFailed++; $display("FAIL l1_stall_after got %b want 0", stall1); end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        #2;
        test_reset();
        preload();
        test_store_load();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
